// File: rtl/onehot_iter_if.sv
// Handshake bundle for onehot_iter: vector intake and one-hot beat output.
// Signal names are seen from the iterator's side (i_ = into it, o_ = out of it).
interface onehot_iter_if #(
  parameter int W = 8
);
  localparam int IW = $clog2(W);

  logic          i_vec_vld;
  logic [W-1:0]  i_vec;
  logic          o_vec_rdy;
  logic          o_oh_vld;
  logic [W-1:0]  o_oh;
  logic [IW-1:0] o_oh_idx;
  logic          o_oh_last;
  logic          i_oh_rdy;

  modport slave (
    input  i_vec_vld, i_vec, i_oh_rdy,
    output o_vec_rdy, o_oh_vld, o_oh, o_oh_idx, o_oh_last
  );

  modport master (
    output i_vec_vld, i_vec, i_oh_rdy,
    input  o_vec_rdy, o_oh_vld, o_oh, o_oh_idx, o_oh_last
  );
endinterface

// File: rtl/onehot_iter.sv
// Walks the set bits of an accepted vector, one one-hot beat per handshake.
// Optional macro ONEHOT_ITER_FLUSH_EN adds i_flush to abort the walk in progress.
module onehot_iter #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           arst_n,
`ifdef ONEHOT_ITER_FLUSH_EN
  input  logic           i_flush,
`endif
  onehot_iter_if.slave   bus
);
  localparam int           IW  = $clog2(W);
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        r_state;
  logic [W-1:0]  r_res;

  logic [W-1:0]  w_oh;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          w_flush;
  logic          w_busy;

`ifdef ONEHOT_ITER_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Isolate the next bit to emit; MSB-first reuses the two's-complement trick on a reversed view.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_oh = r_res & (~r_res + ONE);
    end else begin : g_msb
      logic [W-1:0] w_rev, w_pick;
      for (genvar g = 0; g < W; g++) begin : g_rev
        assign w_rev[g]     = r_res[W-1-g];
        assign w_oh[W-1-g]  = w_pick[g];
      end
      assign w_pick = w_rev & (~w_rev + ONE);
    end
  endgenerate

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < W; i++)
      if (w_oh[i]) w_idx = w_idx | IW'(i);
  end

  assign w_last = (r_res != '0) && ((r_res & (r_res - ONE)) == '0);
  assign w_busy = (r_state == BUSY);

  assign bus.o_vec_rdy = !w_busy && !w_flush;
  assign bus.o_oh_vld  = w_busy;
  assign bus.o_oh      = w_busy ? w_oh   : '0;
  assign bus.o_oh_idx  = w_busy ? w_idx  : '0;
  assign bus.o_oh_last = w_busy ? w_last : 1'b0;

  // Flush wins over both the vector intake and the beat handshake.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_res   <= '0;
    end else if (w_flush) begin
      r_state <= IDLE;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_vec_vld && bus.i_vec != '0) begin
            r_res   <= bus.i_vec;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.i_oh_rdy) begin
            r_res <= r_res & ~w_oh;
            if (w_last) r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_res   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_iter.sv
// Drives an LSB-first and an MSB-first iterator in lockstep and checks them
// against directed expectations and a queue-of-indices reference model.
module tb_onehot_iter;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] vec = 8'h00;
  logic       ordy = 1'b0;
`ifdef ONEHOT_ITER_FLUSH_EN
  logic       flush = 1'b0;
`endif

  always #5 clk = ~clk;

  onehot_iter_if #(.W(8)) bus_a ();
  onehot_iter_if #(.W(8)) bus_b ();

  assign bus_a.i_vec_vld = vld;
  assign bus_a.i_vec     = vec;
  assign bus_a.i_oh_rdy  = ordy;
  assign bus_b.i_vec_vld = vld;
  assign bus_b.i_vec     = vec;
  assign bus_b.i_oh_rdy  = ordy;

  onehot_iter #(.W(8), .LSB_FIRST(1'b1)) dut_a (
    .clk    (clk),
    .arst_n (arst_n),
`ifdef ONEHOT_ITER_FLUSH_EN
    .i_flush(flush),
`endif
    .bus    (bus_a)
  );

  onehot_iter #(.W(8), .LSB_FIRST(1'b0)) dut_b (
    .clk    (clk),
    .arst_n (arst_n),
`ifdef ONEHOT_ITER_FLUSH_EN
    .i_flush(flush),
`endif
    .bus    (bus_b)
  );

  // {o_oh_vld, o_vec_rdy, o_oh, o_oh_idx, o_oh_last}
  wire [13:0] obs_a = {bus_a.o_oh_vld, bus_a.o_vec_rdy, bus_a.o_oh, bus_a.o_oh_idx, bus_a.o_oh_last};
  wire [13:0] obs_b = {bus_b.o_oh_vld, bus_b.o_vec_rdy, bus_b.o_oh, bus_b.o_oh_idx, bus_b.o_oh_last};
  localparam logic [13:0] IDLE_OBS = {1'b0, 1'b1, 8'h00, 3'd0, 1'b0};

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    vld = v; vec = d; ordy = r;
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 2;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL reset_a: got %h expected %h", obs_a, IDLE_OBS); end
    if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL reset_b: got %h expected %h", obs_b, IDLE_OBS); end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_order();
    logic [7:0]  ea [4] = '{8'h02, 8'h04, 8'h20, 8'h80};
    logic [7:0]  eb [4] = '{8'h80, 8'h20, 8'h04, 8'h02};
    logic [2:0]  ia [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [2:0]  ib [4] = '{3'd7, 3'd5, 3'd2, 3'd1};
    logic [13:0] exp_a, exp_b;
    drive(1'b1, 8'hA6, 1'b1);
    checks++;
    if (bus_a.o_vec_rdy !== 1'b1) begin errors++; $display("FAIL order_accept: got rdy %b expected 1", bus_a.o_vec_rdy); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      exp_a = {1'b1, 1'b0, ea[k], ia[k], k == 3};
      exp_b = {1'b1, 1'b0, eb[k], ib[k], k == 3};
      checks += 2;
      if (obs_a !== exp_a) begin errors++; $display("FAIL order_lsb beat%0d: got %h expected %h", k, obs_a, exp_a); end
      if (obs_b !== exp_b) begin errors++; $display("FAIL order_msb beat%0d: got %h expected %h", k, obs_b, exp_b); end
    end
    drive(1'b0, 8'h00, 1'b1);
    checks += 2;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL order_idle_a: got %h expected %h", obs_a, IDLE_OBS); end
    if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL order_idle_b: got %h expected %h", obs_b, IDLE_OBS); end
  endtask

  task automatic test_zero();
    drive(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL zero_a c%0d: got %h expected %h", k, obs_a, IDLE_OBS); end
      if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL zero_b c%0d: got %h expected %h", k, obs_b, IDLE_OBS); end
      drive(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_stall();
    logic [13:0] exp_a, exp_b;
    drive(1'b1, 8'h81, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, k == 3);
      exp_a = {1'b1, 1'b0, 8'h01, 3'd0, 1'b0};
      exp_b = {1'b1, 1'b0, 8'h80, 3'd7, 1'b0};
      checks += 2;
      if (obs_a !== exp_a) begin errors++; $display("FAIL stall_a c%0d: got %h expected %h", k, obs_a, exp_a); end
      if (obs_b !== exp_b) begin errors++; $display("FAIL stall_b c%0d: got %h expected %h", k, obs_b, exp_b); end
    end
    drive(1'b0, 8'h00, 1'b1);
    exp_a = {1'b1, 1'b0, 8'h80, 3'd7, 1'b1};
    exp_b = {1'b1, 1'b0, 8'h01, 3'd0, 1'b1};
    checks += 2;
    if (obs_a !== exp_a) begin errors++; $display("FAIL stall_last_a: got %h expected %h", obs_a, exp_a); end
    if (obs_b !== exp_b) begin errors++; $display("FAIL stall_last_b: got %h expected %h", obs_b, exp_b); end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL stall_idle: got %h expected %h", obs_a, IDLE_OBS); end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp_a, exp_b;
    drive(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      exp_a = {1'b1, 1'b0, 8'(1 << k), 3'(k), 1'b0};
      exp_b = {1'b1, 1'b0, 8'(8'h80 >> k), 3'(7 - k), 1'b0};
      checks += 2;
      if (obs_a !== exp_a) begin errors++; $display("FAIL rstmid_a beat%0d: got %h expected %h", k, obs_a, exp_a); end
      if (obs_b !== exp_b) begin errors++; $display("FAIL rstmid_b beat%0d: got %h expected %h", k, obs_b, exp_b); end
    end
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checks += 2;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL rstmid_in_a: got %h expected %h", obs_a, IDLE_OBS); end
    if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL rstmid_in_b: got %h expected %h", obs_b, IDLE_OBS); end
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks += 2;
      if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL rstmid_after_a c%0d: got %h expected %h", k, obs_a, IDLE_OBS); end
      if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL rstmid_after_b c%0d: got %h expected %h", k, obs_b, IDLE_OBS); end
    end
  endtask

  // Reference: a pending vector is the list of its set-bit indices in emission order.
  task automatic test_random();
    logic        v, r;
    logic [7:0]  d;
    logic [13:0] exp_a, exp_b;
    qa.delete(); qb.delete();
    for (int c = 0; c < 400; c++) begin
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      r = ($urandom_range(0, 3) != 0);
      drive(v, d, r);
      if (qa.size() > 0) begin
        exp_a = {1'b1, 1'b0, 8'(1 << qa[0]), 3'(qa[0]), qa.size() == 1};
        exp_b = {1'b1, 1'b0, 8'(1 << qb[0]), 3'(qb[0]), qb.size() == 1};
      end else begin
        exp_a = IDLE_OBS;
        exp_b = IDLE_OBS;
      end
      checks += 2;
      if (obs_a !== exp_a) begin errors++; $display("FAIL random_a c%0d: got %h expected %h", c, obs_a, exp_a); end
      if (obs_b !== exp_b) begin errors++; $display("FAIL random_b c%0d: got %h expected %h", c, obs_b, exp_b); end
      if (qa.size() > 0) begin
        if (r) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
      end else if (v && d != 8'h00) begin
        for (int i = 0; i < 8; i++)
          if (d[i]) begin qa.push_back(i); qb.push_front(i); end
      end
    end
    while (qa.size() > 0) begin
      drive(1'b0, 8'h00, 1'b1);
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL random_drain: got %h expected %h", obs_a, IDLE_OBS); end
  endtask

`ifdef ONEHOT_ITER_FLUSH_EN
  task automatic test_flush();
    logic [13:0] exp_a, exp_b;
    drive(1'b1, 8'hF0, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    exp_a = {1'b1, 1'b0, 8'h10, 3'd4, 1'b0};
    exp_b = {1'b1, 1'b0, 8'h80, 3'd7, 1'b0};
    checks += 2;
    if (obs_a !== exp_a) begin errors++; $display("FAIL flush_beat0_a: got %h expected %h", obs_a, exp_a); end
    if (obs_b !== exp_b) begin errors++; $display("FAIL flush_beat0_b: got %h expected %h", obs_b, exp_b); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    exp_a = {1'b1, 1'b0, 8'h20, 3'd5, 1'b0};
    checks++;
    if (obs_a !== exp_a) begin errors++; $display("FAIL flush_cycle: got %h expected %h", obs_a, exp_a); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks += 2;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL flush_idle_a: got %h expected %h", obs_a, IDLE_OBS); end
    if (obs_b !== IDLE_OBS) begin errors++; $display("FAIL flush_idle_b: got %h expected %h", obs_b, IDLE_OBS); end
    @(negedge clk);
    vld = 1'b1; vec = 8'h3C; flush = 1'b1;
    #1;
    checks++;
    if (bus_a.o_vec_rdy !== 1'b0) begin errors++; $display("FAIL flush_rdy: got %b expected 0", bus_a.o_vec_rdy); end
    @(negedge clk);
    vld = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (obs_a !== IDLE_OBS) begin errors++; $display("FAIL flush_noaccept: got %h expected %h", obs_a, IDLE_OBS); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_order();
    test_zero();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ONEHOT_ITER_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_iter.md
ONEHOT_ITER -- requirements
Module: onehot_iter

Interface
REQ-001 SHALL have parameter W, default 8: width of the input vector and of the one-hot output; legal W >= 2.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 emits set bits lowest-index first; 0 emits them highest-index first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_vec_vld  input  1  an input vector is offered.
REQ-006 SHALL have port i_vec  input  W  the input bit-vector; any number of bits may be set.
REQ-007 SHALL have port o_vec_rdy  output  1  the block accepts i_vec this cycle.
REQ-008 SHALL have port o_oh_vld  output  1  o_oh, o_oh_idx and o_oh_last are valid.
REQ-009 SHALL have port o_oh  output  W  one-hot: the current set bit of the vector being walked.
REQ-010 SHALL have port o_oh_idx  output  $clog2(W)  binary index of the o_oh bit.
REQ-011 SHALL have port o_oh_last  output  1  o_oh is the final set bit of the current vector.
REQ-012 SHALL have port i_oh_rdy  input  1  the consumer accepts o_oh this cycle.

Function
REQ-013 SHALL implement two states: IDLE and BUSY, plus a W-bit residual register holding the bits not yet emitted.
REQ-014 SHALL drive o_vec_rdy = 1 in IDLE and 0 in BUSY; a vector is accepted on the cycle where i_vec_vld & o_vec_rdy.
REQ-015 On acceptance of a non-zero i_vec, SHALL load residual <= i_vec and move to BUSY; o_oh_vld rises on the next cycle (latency 1).
REQ-016 On acceptance of i_vec == 0, SHALL consume it, stay IDLE and emit no output.
REQ-017 SHALL drive o_oh_vld = 1 exactly when in BUSY.
REQ-018 In BUSY, o_oh SHALL be the lowest set bit of residual (LSB_FIRST=1) or the highest (LSB_FIRST=0); o_oh_idx its index.
REQ-019 o_oh_last SHALL be 1 when residual has exactly one set bit.
REQ-020 On o_oh_vld & i_oh_rdy, residual SHALL clear the o_oh bit; if o_oh_last, SHALL return to IDLE.
REQ-021 While o_oh_vld & !i_oh_rdy, o_oh, o_oh_idx, o_oh_last SHALL hold stable.
REQ-022 A vector with k set bits SHALL produce exactly k beats, with a minimum of one cycle in IDLE between vectors; peak throughput is one beat per cycle.
REQ-023 In IDLE, o_oh, o_oh_idx and o_oh_last SHALL be driven 0.

Reset
REQ-024 While arst_n = 0, SHALL be in IDLE with residual = 0, hence o_vec_rdy = 1, o_oh_vld = 0, o_oh = 0, o_oh_idx = 0, o_oh_last = 0.
REQ-025 Reset asserted mid-vector SHALL discard all unemitted bits; no beat SHALL appear after reset is released until a new vector is accepted.

Configuration
REQ-026 With macro ONEHOT_ITER_FLUSH_EN defined, SHALL add port i_flush  input  1; with it undefined, the port and its logic are absent.
REQ-027 When i_flush = 1, SHALL clear residual and enter IDLE on the next edge, ignoring any o_oh handshake that cycle, and SHALL force o_vec_rdy = 0 that cycle.

Verification
REQ-028 W=8, LSB_FIRST=1, i_vec=8'b1010_0110, i_oh_rdy=1 -> beats o_oh=0x02,0x04,0x20,0x80; idx 1,2,5,7; o_oh_last only on 0x80; then o_vec_rdy=1.
REQ-029 W=8, LSB_FIRST=0, i_vec=8'b1010_0110 -> order 0x80,0x20,0x04,0x02; o_oh_last on 0x02.
REQ-030 i_vec=0 accepted -> o_oh_vld stays 0; o_vec_rdy stays 1.
REQ-031 i_vec=8'h81, i_oh_rdy held 0 for 3 cycles -> o_oh=0x01 stable for 3 cycles, then 0x01, 0x80 after i_oh_rdy=1.
REQ-032 i_vec=8'hFF, arst_n pulsed low after 2 beats -> IDLE, o_oh_vld=0, no further beats.
REQ-033 ONEHOT_ITER_FLUSH_EN defined, i_vec=8'hF0, i_flush=1 after first beat -> next cycle IDLE, o_vec_rdy=1, no further beats.
